// File: rtl/pipeline_step_ctrl.sv
// Run/step controller producing the shared pipeline-register enable.
// Handles run, N-cycle step, pause, one-cycle flush and freezes on HALT at WB.
module pipeline_step_ctrl #(
    parameter int NBITS  = 32,
    parameter int SNBITS = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cmd_run,
    input  logic              i_cmd_step,
    input  logic [SNBITS-1:0] i_step_n,
    input  logic              i_cmd_pause,
    input  logic              i_cmd_clear,
    input  logic              i_halt_wb,
    output logic              o_step,
    output logic              o_pipe_flush,
    output logic [2:0]        o_state,
    output logic              o_halted,
    output logic              o_cmd_ack,
    output logic [NBITS-1:0]  o_cycle_count,
    output logic [SNBITS-1:0] o_steps_left
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_STEP   = 3'd2,
        S_HALTED = 3'd3,
        S_FLUSH  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [SNBITS-1:0] steps_q, steps_d;
    logic [NBITS-1:0]  cnt_q, cnt_d;
    logic              ack;
    logic              step_en;

    // The enable drops in the same cycle HALT reaches WB or reset is asserted.
    assign step_en = ((state_q == S_RUN) || (state_q == S_STEP)) && !i_halt_wb && i_reset;

    always_comb begin
        state_d = state_q;
        steps_d = '0;
        ack     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (i_cmd_clear) begin
                    state_d = S_FLUSH;
                    ack     = 1'b1;
                end else if (i_cmd_run) begin
                    state_d = S_RUN;
                    ack     = 1'b1;
                end else if (i_cmd_step) begin
                    state_d = S_STEP;
                    ack     = 1'b1;
                    steps_d = (i_step_n == '0) ? SNBITS'(1) : i_step_n;
                end
            end
            S_RUN: begin
                if (i_cmd_clear) begin
                    state_d = S_FLUSH;
                    ack     = 1'b1;
                end else if (i_halt_wb) begin
                    state_d = S_HALTED;
                end else if (i_cmd_pause) begin
                    state_d = S_IDLE;
                    ack     = 1'b1;
                end
            end
            S_STEP: begin
                if (i_cmd_clear) begin
                    state_d = S_FLUSH;
                    ack     = 1'b1;
                end else if (i_halt_wb) begin
                    state_d = S_HALTED;
                end else if (i_cmd_pause) begin
                    state_d = S_IDLE;
                    ack     = 1'b1;
                end else if (steps_q <= SNBITS'(1)) begin
                    state_d = S_IDLE;
                end else begin
                    steps_d = steps_q - SNBITS'(1);
                end
            end
            S_HALTED: begin
                if (i_cmd_clear) begin
                    state_d = S_FLUSH;
                    ack     = 1'b1;
                end
            end
            S_FLUSH: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Saturating executed-cycle counter, zeroed at the end of a flush.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_FLUSH)
            cnt_d = '0;
        else if (step_en && (cnt_q != '1))
            cnt_d = cnt_q + NBITS'(1);
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q <= S_IDLE;
            steps_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            steps_q <= steps_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_step        = step_en;
    assign o_pipe_flush  = (state_q == S_FLUSH);
    assign o_state       = state_q;
    assign o_halted      = (state_q == S_HALTED);
    assign o_cmd_ack     = ack && i_reset;
    assign o_cycle_count = cnt_q;
    assign o_steps_left  = steps_q;

endmodule

// File: tb/tb_pipeline_step_ctrl.sv
// Directed bench for pipeline_step_ctrl; per-cycle expectations are queued
// when inputs are driven and checked at the following falling edge.
module tb_pipeline_step_ctrl;

    localparam int NBITS  = 4;
    localparam int SNBITS = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              run, stp, pause, clr, halt;
    logic [SNBITS-1:0] step_n;
    logic              o_step, o_flush, o_halted, o_ack;
    logic [2:0]        o_state;
    logic [NBITS-1:0]  o_cnt;
    logic [SNBITS-1:0] o_left;

    typedef struct {
        logic              step;
        logic              flush;
        logic [2:0]        state;
        logic              ack;
        logic [NBITS-1:0]  cnt;
        logic [SNBITS-1:0] left;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pipeline_step_ctrl #(.NBITS(NBITS), .SNBITS(SNBITS)) dut (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .i_cmd_run     (run),
        .i_cmd_step    (stp),
        .i_step_n      (step_n),
        .i_cmd_pause   (pause),
        .i_cmd_clear   (clr),
        .i_halt_wb     (halt),
        .o_step        (o_step),
        .o_pipe_flush  (o_flush),
        .o_state       (o_state),
        .o_halted      (o_halted),
        .o_cmd_ack     (o_ack),
        .o_cycle_count (o_cnt),
        .o_steps_left  (o_left)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // One clock cycle: drive commands, queue the expected outputs, check at negedge.
    task automatic cyc(input string tag, input logic r, input logic s, input int n,
                       input logic p, input logic c, input logic h, input logic rs,
                       input logic e_step, input logic e_flush, input int e_state,
                       input logic e_ack, input int e_cnt, input int e_left);
        exp_t e;
        exp_t g;
        run = r; stp = s; step_n = SNBITS'(n); pause = p; clr = c; halt = h; rst_n = rs;
        e.step = e_step; e.flush = e_flush; e.state = 3'(e_state); e.ack = e_ack;
        e.cnt = NBITS'(e_cnt); e.left = SNBITS'(e_left);
        exp_q.push_back(e);
        @(negedge clk);
        g = exp_q.pop_front();
        chk({tag, ".step"},   32'(o_step),   32'(g.step));
        chk({tag, ".flush"},  32'(o_flush),  32'(g.flush));
        chk({tag, ".state"},  32'(o_state),  32'(g.state));
        chk({tag, ".halted"}, 32'(o_halted), 32'(g.state == 3'd3));
        chk({tag, ".ack"},    32'(o_ack),    32'(g.ack));
        chk({tag, ".cnt"},    32'(o_cnt),    32'(g.cnt));
        chk({tag, ".left"},   32'(o_left),   32'(g.left));
        @(posedge clk);
        #1;
    endtask

    // Idle cycle (no commands, reset released) with expectations.
    task automatic nop(input string tag, input logic e_step, input logic e_flush,
                       input int e_state, input int e_cnt, input int e_left);
        cyc(tag, 0, 0, 0, 0, 0, 0, 1, e_step, e_flush, e_state, 0, e_cnt, e_left);
    endtask

    initial begin
        run = 0; stp = 0; step_n = '0; pause = 0; clr = 0; halt = 0; rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        // reset released: everything zero
        nop("reset", 0, 0, 0, 0, 0);

        // step of 3
        cyc("step3_cmd", 0, 1, 3, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
        nop("step3_c1", 1, 0, 2, 0, 3);
        nop("step3_c2", 1, 0, 2, 1, 2);
        nop("step3_c3", 1, 0, 2, 2, 1);
        nop("step3_end", 0, 0, 0, 3, 0);

        // step of 0 behaves as 1
        cyc("step0_cmd", 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 3, 0);
        nop("step0_c1", 1, 0, 2, 3, 1);
        nop("step0_end", 0, 0, 0, 4, 0);

        // pause and halt in IDLE do nothing
        cyc("idle_pause", 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 4, 0);

        // clear from IDLE
        cyc("clr_cmd", 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 4, 0);
        nop("clr_flush", 0, 1, 4, 4, 0);
        nop("clr_idle", 0, 0, 0, 0, 0);

        // run, halt on 5th run cycle
        cyc("run_cmd", 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) nop("run_cyc", 1, 0, 1, i, 0);
        cyc("run_halt", 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 4, 0);
        nop("halted", 0, 0, 3, 4, 0);
        cyc("halted_run", 1, 0, 0, 0, 0, 0, 1, 0, 0, 3, 0, 4, 0);

        // clear from HALTED, then run accepted
        cyc("hclr_cmd", 0, 0, 0, 0, 1, 0, 1, 0, 0, 3, 1, 4, 0);
        nop("hclr_flush", 0, 1, 4, 4, 0);
        cyc("hclr_run", 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
        nop("run2_c1", 1, 0, 1, 0, 0);
        cyc("run2_rerun", 1, 1, 2, 0, 0, 0, 1, 1, 0, 1, 0, 1, 0);
        // pause and halt together: halt wins
        cyc("run2_ph", 0, 0, 0, 1, 0, 1, 1, 0, 0, 1, 0, 2, 0);
        nop("run2_halted", 0, 0, 3, 2, 0);
        cyc("run2_clr", 0, 0, 0, 0, 1, 0, 1, 0, 0, 3, 1, 2, 0);
        nop("run2_flush", 0, 1, 4, 2, 0);

        // step of 5 interrupted by reset
        cyc("s5_cmd", 0, 1, 5, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
        cyc("s5_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 5);
        nop("s5_after", 0, 0, 0, 0, 0);

        // step of 4 interrupted by pause
        cyc("s4_cmd", 0, 1, 4, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
        nop("s4_c1", 1, 0, 2, 0, 4);
        cyc("s4_pause", 0, 0, 0, 1, 0, 0, 1, 1, 0, 2, 1, 1, 3);
        nop("s4_after", 0, 0, 0, 2, 0);

        // halt during STEP
        cyc("sh_cmd", 0, 1, 6, 0, 0, 0, 1, 0, 0, 0, 1, 2, 0);
        nop("sh_c1", 1, 0, 2, 2, 6);
        cyc("sh_halt", 0, 0, 0, 0, 0, 1, 1, 0, 0, 2, 0, 3, 5);
        nop("sh_halted", 0, 0, 3, 3, 0);
        cyc("sh_clr", 0, 0, 0, 0, 1, 0, 1, 0, 0, 3, 1, 3, 0);
        nop("sh_flush", 0, 1, 4, 3, 0);

        // counter saturation at all-ones
        cyc("sat_run", 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 18; i++) nop("sat_cyc", 1, 0, 1, (i > 15) ? 15 : i, 0);
        cyc("sat_pause", 0, 0, 0, 1, 0, 0, 1, 1, 0, 1, 1, 15, 0);
        nop("sat_idle", 0, 0, 0, 15, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipeline_step_ctrl.md
# pipeline_step_ctrl

Run/step controller that generates the common `o_step` enable for every pipeline register (IF_ID, ID_EX, EX_MEM, MEM_WB) of the MIPS core. It supports:
- continuous run;
- N-cycle single-stepping;
- pause;
- a one-cycle pipeline flush.

It freezes the pipeline when the HALT flag reaches the MEM/WB output. It also keeps a count of executed pipeline cycles for the debug unit.

## Interface

Parameters:
- `NBITS`, 32, width of the executed-cycle counter
- `SNBITS`, 8, width of the step-count request and the remaining-step counter

Ports:
- `i_clk`, in, 1, single clock; all state updates on its rising edge
- `i_reset`, in, 1, synchronous, active-low reset
- `i_cmd_run`, in, 1, one-cycle request: continuous run
- `i_cmd_step`, in, 1, one-cycle request: execute `i_step_n` cycles
- `i_step_n`, in, SNBITS, step count sampled with `i_cmd_step`; 0 treated as 1
- `i_cmd_pause`, in, 1, one-cycle request: stop stepping
- `i_cmd_clear`, in, 1, one-cycle request: flush pipeline and clear counter
- `i_halt_wb`, in, 1, HALT flag at the MEM/WB register output
- `o_step`, out, 1, enable to all pipeline registers
- `o_pipe_flush`, out, 1, one-cycle flush pulse to the pipeline registers
- `o_state`, out, 3, IDLE=0, RUN=1, STEP=2, HALTED=3, FLUSH=4
- `o_halted`, out, 1, high while in HALTED
- `o_cmd_ack`, out, 1, high in the cycle a command is accepted
- `o_cycle_count`, out, NBITS, count of cycles with `o_step`=1 since the last reset or flush
- `o_steps_left`, out, SNBITS, remaining steps in STEP; 0 in all other states

## Operation

Reset:
- `i_reset`=0 sampled at an edge puts the block in IDLE.
- Reset values: `o_cycle_count`=0, `o_steps_left`=0, `o_step`=0, `o_pipe_flush`=0, `o_halted`=0, `o_cmd_ack`=0, `o_state`=0.

Combinational outputs:
- `o_step` = (state is RUN or STEP) AND `i_halt_wb`=0 AND `i_reset`=1.
- When HALT is at WB, the pipeline is frozen in that same cycle.

Command handling:
- Priority within a cycle: clear > halt > pause > run > step.
- A command that is not accepted in the current state is dropped and produces no ack.

Per-state transitions:
- IDLE:
  - clear → FLUSH
  - run → RUN
  - step → STEP, with `o_steps_left` loaded as max(`i_step_n`, 1)
  - pause → ignored
- RUN:
  - clear → FLUSH
  - `i_halt_wb`=1 → HALTED
  - pause → IDLE (acked)
  - run and step → ignored
- STEP:
  - `o_steps_left` decrements on each cycle with `o_step`=1.
  - clear → FLUSH
  - halt → HALTED
  - pause → IDLE (acked), and `o_steps_left` → 0
  - when `o_step`=1 and `o_steps_left`=1 → IDLE
  - run and step → ignored
- HALTED:
  - `o_step`=0
  - only clear is accepted → FLUSH
- FLUSH:
  - lasts exactly one cycle, then → IDLE
  - `o_pipe_flush`=1 and `o_step`=0
  - `o_cycle_count` → 0 at the end of the cycle
  - all commands ignored

Cycle counter:
- `o_cycle_count` increments by 1 on each edge where `o_step`=1.
- It saturates at all-ones; no wrap-around.

## Timing

- Command sampled at edge k: new state is visible after edge k. The first `o_step`=1 is in cycle k+1.
- `o_cmd_ack` is combinational: it is high in the same cycle as the accepted command.
- STEP with N: exactly N consecutive cycles with `o_step`=1, then IDLE. An interrupting halt, pause or clear shortens this.
- Halt in RUN or STEP:
  - `o_step` drops in the same cycle `i_halt_wb` rises.
  - The state becomes HALTED after the next edge.
  - The cycle counter does not count that cycle.
- Halt and pause together: halt wins, so the state goes to HALTED.
- Clear in any state except FLUSH: FLUSH for one cycle, then IDLE.
  - Minimum latency from clear to the next run is 2 cycles.
- Reset mid-RUN or mid-STEP: `o_step`=0 in the cycle reset is low. State is IDLE after the edge and the counters are zeroed.
- `i_halt_wb`=1 while in IDLE has no effect. `o_step` is already 0.

## Test plan

- **Reset:** hold `i_reset`=0 for 2 cycles, then release → all outputs 0 and `o_state`=0.
- **Step of 3:** `i_cmd_step` with `i_step_n`=3 in IDLE.
  - `o_cmd_ack`=1 in the command cycle.
  - `o_step`=1 for exactly 3 cycles with `o_steps_left` 3,2,1.
  - Then IDLE, with `o_cycle_count`=3.
- **Step of 0:** `i_step_n`=0 → exactly one `o_step` cycle.
- **Run then halt:** `i_cmd_run`, then `i_halt_wb`=1 on the 5th run cycle.
  - `o_step`=0 in that cycle and `o_cycle_count`=4.
  - Next state is HALTED with `o_halted`=1.
  - A following `i_cmd_run` gives no ack and no `o_step`.
- **Clear from HALTED:** `i_cmd_clear` → `o_pipe_flush`=1 for one cycle, then IDLE with `o_cycle_count`=0. A following run is accepted.
- **Simultaneous and edge cases:**
  - In RUN, pause and halt in the same cycle → HALTED.
  - In STEP with `o_steps_left`=5, reset low for 1 cycle → IDLE with `o_steps_left`=0.
  - Preload the counter to all-ones − 1 and run 3 cycles → counter stays at all-ones.
